// File: rtl/noc_flit_pkg.sv
// noc_flit_pkg: flit encodings, packet register layout and flit builders
// for the local-port packet injector.
package noc_flit_pkg;
  localparam logic [1:0] FLIT_HEAD = 2'b00;
  localparam logic [1:0] FLIT_BODY = 2'b01;
  localparam logic [1:0] FLIT_TAIL = 2'b10;
  localparam int BODY_FLITS = 5;
  localparam logic [2:0] LAST_BODY = 3'(BODY_FLITS - 1);
  localparam int PKT_COORD_W = 3;
  localparam int PAYLOAD_W = 30;
  localparam int TAIL_W = 2;
  typedef enum logic [1:0] {S_IDLE, S_HEAD, S_BODY, S_TAIL} state_t;
  typedef struct packed {
    logic [PKT_COORD_W-1:0] x;
    logic [PKT_COORD_W-1:0] y;
    logic [PAYLOAD_W-1:0] payload;
    logic [TAIL_W-1:0] tail;
  } packet_t;
  function automatic logic [7:0] head_flit(input packet_t p);
    return {p.x, p.y, FLIT_HEAD};
  endfunction
  // body k carries payload[29-6k:24-6k]; shifting left brings that slice to the top
  function automatic logic [7:0] body_flit(input logic [PAYLOAD_W-1:0] payload, input logic [2:0] k);
    logic [PAYLOAD_W-1:0] s;
    s = payload << (6 * k);
    return {s[29:24], FLIT_BODY};
  endfunction
  function automatic logic [7:0] tail_flit(input logic [TAIL_W-1:0] tail);
    return {tail, 4'b0000, FLIT_TAIL};
  endfunction
endpackage

// File: rtl/noc_rr_arbiter.sv
// noc_rr_arbiter: one-hot round-robin grant; the pointer moves just past
// the winner when the grant is taken (advance).
module noc_rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant
);
  localparam int PW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_next;
  // scan from lowest to highest priority so the highest-priority hit is kept last
  always_comb begin
    int k;
    grant = '0;
    w_next = r_ptr;
    k = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      k = (int'(r_ptr) + i) % NUM_REQ;
      if (|(req & (NUM_REQ'(1) << k))) begin
        grant = NUM_REQ'(1) << k;
        w_next = PW'((k + 1) % NUM_REQ);
      end
    end
  end
  always_ff @(posedge clk)
    if (rst) r_ptr <= '0;
    else if (advance) r_ptr <= w_next;
endmodule

// File: rtl/noc_packet_injector.sv
// noc_packet_injector: arbitrates requesters round-robin and serialises the
// granted message into a head/5-body/tail wormhole packet on the local port.
module noc_packet_injector
  import noc_flit_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int LINK_WIDTHS = 8,
  parameter int COORD_W = 3,
  parameter int CNT_W = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*COORD_W-1:0]   req_dest_x,
  input  logic [NUM_REQ*COORD_W-1:0]   req_dest_y,
  input  logic [NUM_REQ*PAYLOAD_W-1:0] req_payload,
  input  logic [NUM_REQ*TAIL_W-1:0]    req_tail,
  input  logic                         router_out_full,
  output logic [LINK_WIDTHS-1:0]       local_in_flit,
  output logic                         local_wr_en,
  output logic                         busy,
  output logic                         pkt_done,
  output logic [CNT_W-1:0]             pkt_count
);
  state_t r_state;
  logic [2:0] r_idx;
  packet_t r_pkt;
  packet_t w_sel;
  logic [7:0] r_flit;
  logic r_done;
  logic [CNT_W-1:0] r_cnt;
  logic [NUM_REQ-1:0] w_grant;
  logic w_accept;
  logic w_last;
  noc_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk(clk),
    .rst(rst),
    .req(req_valid),
    .advance(w_accept),
    .grant(w_grant)
  );
  always_comb begin
    w_sel = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (w_grant[i])
        w_sel = '{x: req_dest_x[i*COORD_W +: COORD_W], y: req_dest_y[i*COORD_W +: COORD_W],
                  payload: req_payload[i*PAYLOAD_W +: PAYLOAD_W], tail: req_tail[i*TAIL_W +: TAIL_W]};
  end
  assign w_accept = (r_state == S_IDLE) & |req_valid & ~rst;
  assign req_ready = w_accept ? w_grant : '0;
  assign local_wr_en = (r_state != S_IDLE) & ~router_out_full & ~rst;
  assign w_last = (r_state == S_TAIL) & local_wr_en;
  assign busy = r_state != S_IDLE;
  assign local_in_flit = r_flit;
  assign pkt_done = r_done;
  assign pkt_count = r_cnt;
  always_ff @(posedge clk)
    if (rst) begin
      r_state <= S_IDLE;
      r_idx <= '0;
      r_pkt <= '0;
      r_flit <= '0;
      r_done <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_done <= w_last;
      if (w_last) r_cnt <= r_cnt + CNT_W'(1);
      if (w_accept) begin
        r_pkt <= w_sel;
        r_flit <= head_flit(w_sel);
        r_state <= S_HEAD;
        r_idx <= '0;
      end else if (local_wr_en) begin
        r_state <= r_state == S_HEAD ? S_BODY : r_state == S_TAIL ? S_IDLE :
                   r_idx == LAST_BODY ? S_TAIL : S_BODY;
        r_idx <= r_state == S_BODY ? r_idx + 3'd1 : '0;
        r_flit <= r_state == S_TAIL ? '0 :
                  (r_state == S_BODY && r_idx == LAST_BODY) ? tail_flit(r_pkt.tail) :
                  body_flit(r_pkt.payload, r_state == S_HEAD ? 3'd0 : r_idx + 3'd1);
      end
    end
endmodule

// File: tb/tb_noc_packet_injector.sv
// tb_noc_packet_injector: directed checks of flit sequence, backpressure,
// arbitration order, grant under full, reset mid-packet and counter wrap.
module tb_noc_packet_injector;
  localparam int NR = 2;
  localparam int CW = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NR-1:0] req_valid = '0;
  logic [NR-1:0] req_ready;
  logic [NR*3-1:0] req_dest_x = {3'd5, 3'd3};
  logic [NR*3-1:0] req_dest_y = {3'd2, 3'd3};
  logic [NR*30-1:0] req_payload = {30'h2AAAAAAA, 30'h3FFFFFF};
  logic [NR*2-1:0] req_tail = {2'b01, 2'b10};
  logic router_out_full = 1'b0;
  logic [7:0] local_in_flit;
  logic local_wr_en, busy, pkt_done;
  logic [CW-1:0] pkt_count;
  int passed = 0;
  int total = 0;
  int n_wr = 0;
  int cyc = 0;
  int c0, w0;
  logic [55:0] e0 = 56'h6C0DFDFDFDFD82;
  logic [55:0] e1 = 56'hA8A9A9A9A9A942;

  noc_packet_injector #(.NUM_REQ(NR), .LINK_WIDTHS(8), .COORD_W(3), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_dest_x(req_dest_x), .req_dest_y(req_dest_y), .req_payload(req_payload),
    .req_tail(req_tail), .router_out_full(router_out_full), .local_in_flit(local_in_flit),
    .local_wr_en(local_wr_en), .busy(busy), .pkt_done(pkt_done), .pkt_count(pkt_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (local_wr_en) n_wr <= n_wr + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // call right after the accepting edge; waits (bounded) through stalls for each flit
  task automatic expect_pkt(input string tag, input logic [55:0] e);
    int n;
    for (int k = 0; k < 7; k++) begin
      n = 0;
      while (!local_wr_en && n < 20) begin
        tick();
        n++;
      end
      chk($sformatf("%s_wr%0d", tag, k), {31'd0, local_wr_en}, 32'd1);
      chk($sformatf("%s_flit%0d", tag, k), {24'd0, local_in_flit}, {24'd0, e[55-8*k -: 8]});
      tick();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    req_valid = 2'b01;
    tick();
    tick();
    chk("rst_flit", {24'd0, local_in_flit}, 32'h0);
    chk("rst_wr", {31'd0, local_wr_en}, 32'd0);
    chk("rst_ready", {30'd0, req_ready}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, pkt_done}, 32'd0);
    chk("rst_count", {30'd0, pkt_count}, 32'd0);
    req_valid = 2'b00;
    rst = 1'b0;
    tick();
    // single packet
    req_valid = 2'b01;
    #1;
    chk("single_ready", {30'd0, req_ready}, 32'd1);
    tick();
    req_valid = 2'b00;
    c0 = cyc;
    w0 = n_wr;
    chk("single_busy", {31'd0, busy}, 32'd1);
    expect_pkt("single", e0);
    chk("single_done", {31'd0, pkt_done}, 32'd1);
    chk("single_count", {30'd0, pkt_count}, 32'd1);
    chk("single_cycles", cyc - c0, 32'd7);
    chk("single_idle_flit", {24'd0, local_in_flit}, 32'h0);
    tick();
    chk("single_done_pulse", {31'd0, pkt_done}, 32'd0);
    chk("single_writes", n_wr - w0, 32'd7);
    // backpressure on body 2
    req_valid = 2'b01;
    #1;
    chk("bp_ready", {30'd0, req_ready}, 32'd1);
    tick();
    req_valid = 2'b00;
    c0 = cyc;
    w0 = n_wr;
    for (int k = 0; k < 7; k++) begin
      if (k == 3)
        for (int s = 0; s < 3; s++) begin
          router_out_full = 1'b1;
          #1;
          chk($sformatf("bp_stall_wr%0d", s), {31'd0, local_wr_en}, 32'd0);
          chk($sformatf("bp_stall_flit%0d", s), {24'd0, local_in_flit}, 32'hFD);
          tick();
        end
      router_out_full = 1'b0;
      #1;
      chk($sformatf("bp_flit%0d", k), {24'd0, local_in_flit}, {24'd0, e0[55-8*k -: 8]});
      tick();
    end
    chk("bp_done", {31'd0, pkt_done}, 32'd1);
    chk("bp_count", {30'd0, pkt_count}, 32'd2);
    chk("bp_cycles", cyc - c0, 32'd10);
    chk("bp_writes", n_wr - w0, 32'd7);
    // contention from reset: grants alternate 0,1,0,1
    rst = 1'b1;
    req_valid = 2'b11;
    tick();
    chk("cont_rst_ready", {30'd0, req_ready}, 32'd0);
    rst = 1'b0;
    #1;
    for (int p = 0; p < 4; p++) begin
      chk($sformatf("cont_grant%0d", p), {30'd0, req_ready}, (p % 2 == 1) ? 32'd2 : 32'd1);
      tick();
      chk($sformatf("cont_busy_ready%0d", p), {30'd0, req_ready}, 32'd0);
      w0 = n_wr;
      expect_pkt($sformatf("cont%0d", p), (p % 2 == 1) ? e1 : e0);
      chk($sformatf("cont_writes%0d", p), n_wr - w0, 32'd7);
      chk($sformatf("cont_count%0d", p), {30'd0, pkt_count}, (p + 1) % 4);
    end
    req_valid = 2'b00;
    // grant while router full; head held until full drops
    router_out_full = 1'b1;
    req_valid = 2'b10;
    #1;
    chk("gf_ready", {30'd0, req_ready}, 32'd2);
    tick();
    req_valid = 2'b00;
    for (int s = 0; s < 3; s++) begin
      chk($sformatf("gf_hold_wr%0d", s), {31'd0, local_wr_en}, 32'd0);
      chk($sformatf("gf_hold_flit%0d", s), {24'd0, local_in_flit}, 32'hA8);
      tick();
    end
    router_out_full = 1'b0;
    #1;
    expect_pkt("gf", e1);
    chk("gf_count", {30'd0, pkt_count}, 32'd1);
    // reset during body 1
    req_valid = 2'b01;
    #1;
    tick();
    req_valid = 2'b00;
    tick();
    tick();
    chk("rm_body1", {24'd0, local_in_flit}, 32'hFD);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("rm_flit", {24'd0, local_in_flit}, 32'h0);
    chk("rm_wr", {31'd0, local_wr_en}, 32'd0);
    chk("rm_busy", {31'd0, busy}, 32'd0);
    chk("rm_done", {31'd0, pkt_done}, 32'd0);
    chk("rm_count", {30'd0, pkt_count}, 32'd0);
    req_valid = 2'b10;
    #1;
    chk("rm_grant", {30'd0, req_ready}, 32'd2);
    tick();
    req_valid = 2'b00;
    w0 = n_wr;
    expect_pkt("rm", e1);
    chk("rm_writes", n_wr - w0, 32'd7);
    chk("rm_count_after", {30'd0, pkt_count}, 32'd1);
    // counter wrap with CNT_W = 2
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int p = 0; p < 5; p++) begin
      req_valid = 2'b01;
      #1;
      tick();
      req_valid = 2'b00;
      expect_pkt($sformatf("wrap%0d", p), e0);
      chk($sformatf("wrap_count%0d", p), {30'd0, pkt_count}, (p + 1) % 4);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/noc_packet_injector.md
# noc_packet_injector

Local-port injection controller for one mesh router. Arbitrates round-robin among `NUM_REQ` requesters, such as a core and a DMA engine, each offering a destination plus a 32-bit message. Serializes the granted message into one 7-flit wormhole packet on the router's local input: 1 head, 5 body, 1 tail. Honours `router_out_full` backpressure flit by flit and never drops, duplicates or interleaves flits between packets.

## Interface
- `NUM_REQ`, 2: number of requesters, 1–8.
- `LINK_WIDTHS`, 8: flit width; only 8 is supported.
- `COORD_W`, 3: width of each destination coordinate.
- `CNT_W`, 16: width of the sent-packet counter.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  NUM_REQ  per-requester request.
- `req_ready`  out  NUM_REQ  one-hot grant; the request is accepted on `valid & ready`.
- `req_dest_x`  in  NUM_REQ*3  destination X, flattened with requester i at `[3i+2:3i]`.
- `req_dest_y`  in  NUM_REQ*3  destination Y, same packing.
- `req_payload`  in  NUM_REQ*30  30-bit payload per requester.
- `req_tail`  in  NUM_REQ*2  2-bit tail data per requester.
- `router_out_full`  in  1  router local buffer full.
- `local_in_flit`  out  8  flit to the router.
- `local_wr_en`  out  1  flit write strobe.
- `busy`  out  1  packet in flight.
- `pkt_done`  out  1  one-cycle pulse when the tail flit is written.
- `pkt_count`  out  CNT_W  number of packets completed, wrapping.

## Operation
- **Flit encoding:**
  - Head: `{dest_x, dest_y, 2'b00}`.
  - Body k = 0..4: `{payload[29-6k:24-6k], 2'b01}`.
  - Tail: `{tail, 4'b0000, 2'b10}`.
- **FSM states:** IDLE, HEAD, BODY, TAIL. A 3-bit body index runs 0..4.
- **IDLE:**
  - If any `req_valid` is high, assert the round-robin grant on `req_ready`.
  - On that edge, latch dest, payload and tail into the packet register, then go to HEAD.
  - Requesters hold their fields stable while valid until granted.
- **Flit write rule:** a flit is written on a cycle where `local_wr_en` is 1. `local_wr_en = (state != IDLE) & ~router_out_full`, which is the only combinational path.
- **HEAD:** on a write, go to BODY with index 0.
- **BODY:** on a write, increment the index. The write with index 4 goes to TAIL.
- **TAIL:** on a write, go to IDLE, pulse `pkt_done` and increment `pkt_count`.
- **Backpressure:** with full asserted, the state and `local_in_flit` hold and nothing is skipped.
- **Arbitration:**
  - The priority pointer resets to 0.
  - After a grant to requester g, the pointer moves to (g+1) mod NUM_REQ.
  - The pointer is unchanged when there is no grant.
- **Grant and full are independent:** a grant is issued even while `router_out_full` is high. The head flit then waits.
- `req_ready` is 0 outside IDLE.
- **Idle output:** `local_in_flit` is 8'h00 in IDLE.

## Timing
- **Reset values:**
  - State IDLE, pointer 0, packet register 0.
  - `local_in_flit` = 0, `local_wr_en` = 0, `req_ready` = 0 during `rst`, `busy` = 0, `pkt_done` = 0, `pkt_count` = 0.
- **Registered outputs:** `local_in_flit` is registered from state and index. The head flit is valid in the cycle after acceptance.
- **Packet period:** 7 cycles minimum plus 1 IDLE cycle, so a new packet starts at most every 8 cycles.
- **`busy`:** equals `state != IDLE`.
- **`pkt_done`:** registered, high in the cycle after the tail write.
- **Counter:** `pkt_count` wraps at 2^CNT_W − 1 to 0.
- **Full at the last flit:** if full is asserted during TAIL, the tail waits and `pkt_done` is delayed accordingly.
- **Reset mid-packet:** the packet is abandoned immediately and the remaining flits are not sent. Router-side recovery is a system concern; routers are reset together.

## Structure
- **Package `noc_flit_pkg`:**
  - Constants FLIT_HEAD = 2'b00, FLIT_BODY = 2'b01, FLIT_TAIL = 2'b10.
  - Constant BODY_FLITS = 5.
  - Coordinate and payload widths.
  - State enum.
  - Flit-building functions.
- **Sub-module `noc_rr_arbiter`:** parameterised by `NUM_REQ`, inputs `req` and `advance`, one-hot `grant` output, holds the pointer register.
- **Top level:** contains the FSM, packet register, output register and counter.

## Test plan
- **Single packet:** requester 0 sends dest (3,3), payload 30'h3FFFFFF, tail 2'b10, full = 0.
  - Flits 6C, 0D, FD, FD, FD, FD, 82 on 7 consecutive cycles.
  - `pkt_done` then pulses once and `pkt_count` = 1.
- **Backpressure:** same packet, full held high for 3 cycles while body 2 is presented.
  - `local_wr_en` = 0 for those 3 cycles and the flit holds FD.
  - Exactly 7 writes, completing 3 cycles later than the single-packet case.
- **Contention:** both requesters valid from reset.
  - Grant order is 0, 1, 0, 1.
  - No flit interleaving: each packet's 7 writes are contiguous apart from stalls.
- **Grant under full:** full high in IDLE while requester 1 is valid.
  - The grant still occurs and the head is held until full drops.
  - The head is then written, followed by the remaining 6 flits.
- **Reset mid-packet:** `rst` pulsed during body 1.
  - Next cycle: all outputs 0 and state IDLE.
  - A following request yields a complete, fresh 7-flit packet.
- **Counter wrap:** with CNT_W = 2, send 5 packets.
  - `pkt_count` reads 1, 2, 3, 0, 1.
